// File: rtl/uart_sample_tx_pkg.sv
// Shared constants and state encodings for the framed audio-sample UART transmitter.
package uart_sample_tx_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 3;

  typedef enum logic [2:0] {
    F_IDLE,
    F_LOAD,
    F_HDR,
    F_HI,
    F_LO
  } frame_state_t;

  typedef enum logic [1:0] {
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with a power-of-two depth and an occupancy count; cleared by rst.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_sample_tx.sv
// Sends each buffered 16-bit sample as an 8N1 frame: sync byte 0xA5, high byte, low byte.
module uart_sample_tx
  import uart_sample_tx_pkg::*;
#(
  parameter int CLK_RATE   = 12000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        tx_bits,
  output logic        busy
);

  localparam int BIT_CYCLES = CLK_RATE / BAUD_RATE;
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  logic                         w_full;
  logic                         w_empty;
  logic                         w_push;
  logic                         w_pop;
  logic [15:0]                  w_head;
  logic [$clog2(FIFO_DEPTH):0]  w_count;
  logic                         w_bit_end;

  frame_state_t     r_fstate;
  byte_state_t      r_bstate;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [15:0]      r_frame;
  logic             r_tx;
  logic             r_busy;

  assign sample_ready = !w_full && !rst;
  assign w_push       = sample_valid && sample_ready;
  assign w_pop        = (r_fstate == F_LOAD);
  assign w_bit_end    = (r_cnt == CNT_LAST);
  assign tx_bits      = r_tx;
  assign busy         = r_busy;

  sample_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (sample),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // busy tracks the state/FIFO occupancy that will hold after this edge, so it
  // drops on the same edge the last stop bit ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fstate  <= F_IDLE;
      r_bstate  <= B_START;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_fstate)
        F_IDLE: begin
          r_busy <= !w_empty || w_push;
          if (w_count != '0) r_fstate <= F_LOAD;
        end
        F_LOAD: begin
          r_busy   <= 1'b1;
          r_frame  <= w_head;
          r_shift  <= SYNC_BYTE;
          r_bstate <= B_START;
          r_cnt    <= '0;
          r_tx     <= 1'b0;
          r_fstate <= F_HDR;
        end
        default: begin
          r_busy <= 1'b1;
          if (!w_bit_end) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
            case (r_bstate)
              B_START: begin
                r_bstate  <= B_DATA;
                r_bit_idx <= '0;
                r_tx      <= r_shift[0];
              end
              B_DATA: begin
                if (r_bit_idx == 3'd7) begin
                  r_bstate <= B_STOP;
                  r_tx     <= 1'b1;
                end else begin
                  r_bit_idx <= r_bit_idx + 3'd1;
                  r_tx      <= r_shift[r_bit_idx + 3'd1];
                end
              end
              default: begin
                // Stop bit done: chain straight into the next byte's start bit.
                r_bstate <= B_START;
                case (r_fstate)
                  F_HDR: begin
                    r_fstate <= F_HI;
                    r_shift  <= r_frame[15:8];
                    r_tx     <= 1'b0;
                  end
                  F_HI: begin
                    r_fstate <= F_LO;
                    r_shift  <= r_frame[7:0];
                    r_tx     <= 1'b0;
                  end
                  default: begin
                    r_fstate <= F_IDLE;
                    r_busy   <= !w_empty || w_push;
                  end
                endcase
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sample_tx.sv
// Directed/randomised bench: decodes the serial line back into bytes and compares with expected frames.
module tb_uart_sample_tx;

  localparam int BC0 = 12000000 / 115200;
  localparam int BC1 = 1000 / 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample0, sample1;
  logic        valid0, valid1;
  logic        ready0, ready1, tx0, tx1, busy0, busy1;

  always #5 clk = ~clk;

  uart_sample_tx dut0 (
    .clk(clk), .rst(rst), .sample(sample0), .sample_valid(valid0),
    .sample_ready(ready0), .tx_bits(tx0), .busy(busy0)
  );

  uart_sample_tx #(.CLK_RATE(1000), .BAUD_RATE(100), .FIFO_DEPTH(8)) dut1 (
    .clk(clk), .rst(rst), .sample(sample1), .sample_valid(valid1),
    .sample_ready(ready1), .tx_bits(tx1), .busy(busy1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    int         start;
    bit         ok;
  } rx_t;

  rx_t q0[$];
  rx_t q1[$];
  int  nassert = 0;
  int  nfail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line decoder: every bit must hold one level for the whole bit period.
  task automatic monitor(input int m);
    rx_t  e;
    logic v, bitv;
    bit   abort;
    int   bc, idx;
    bc = (m == 0) ? BC0 : BC1;
    bitv = 1'b1;
    forever begin
      tick();
      v = (m == 0) ? tx0 : tx1;
      if (!rst && v === 1'b0) begin
        e.start = cyc; e.ok = 1'b1; e.b = '0; abort = 1'b0;
        for (int i = 0; i < 10 * bc; i++) begin
          if (i > 0) tick();
          if (rst) begin abort = 1'b1; break; end
          v = (m == 0) ? tx0 : tx1;
          if (i % bc == 0) begin
            bitv = v;
            idx  = i / bc;
            if (idx == 0 && v !== 1'b0) e.ok = 1'b0;
            if (idx == 9 && v !== 1'b1) e.ok = 1'b0;
            if (idx >= 1 && idx <= 8) e.b[idx-1] = v;
          end else if (v !== bitv) begin
            e.ok = 1'b0;
          end
        end
        if (!abort) begin
          if (m == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic push(input int m, input logic [15:0] s, output int n);
    int g;
    g = 0;
    if (m == 0) begin sample0 = s; valid0 = 1'b1; end
    else        begin sample1 = s; valid1 = 1'b1; end
    while (((m == 0) ? ready0 : ready1) !== 1'b1 && g < 5000) begin tick(); g++; end
    chk("push_ready_wait", g < 5000, 1);
    tick();
    n = cyc;
    if (m == 0) valid0 = 1'b0; else valid1 = 1'b0;
  endtask

  task automatic wait_bytes(input int m, input int k, input int limit);
    int g;
    g = 0;
    while (((m == 0) ? q0.size() : q1.size()) < k && g < limit) begin tick(); g++; end
  endtask

  task automatic check_frame(input int m, input logic [15:0] s, output int st);
    rx_t e[3];
    int  bc, sz;
    bc = (m == 0) ? BC0 : BC1;
    sz = (m == 0) ? q0.size() : q1.size();
    st = 0;
    chk("frame_available", sz >= 3, 1);
    if (sz < 3) return;
    for (int i = 0; i < 3; i++) begin
      if (m == 0) e[i] = q0.pop_front(); else e[i] = q1.pop_front();
    end
    chk("byte_sync", e[0].b, 8'hA5);
    chk("byte_hi",   e[1].b, s[15:8]);
    chk("byte_lo",   e[2].b, s[7:0]);
    chk("bit_shape", e[0].ok & e[1].ok & e[2].ok, 1);
    chk("byte1_spacing", e[1].start - e[0].start, 10 * bc);
    chk("byte2_spacing", e[2].start - e[1].start, 10 * bc);
    st = e[0].start;
  endtask

  task automatic wait_idle(input int m);
    int g;
    g = 0;
    while (((m == 0) ? busy0 : busy1) === 1'b1 && g < 10000) begin tick(); g++; end
    chk("idle_wait", g < 10000, 1);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, s, prev, acc, k, g, tgt;
    logic [15:0] v;
    logic [15:0] expq[$];

    rst = 1'b1; valid0 = 1'b0; valid1 = 1'b0; sample0 = '0; sample1 = '0;
    repeat (3) tick();
    chk("rst_tx0", tx0, 1);
    chk("rst_busy0", busy0, 0);
    chk("rst_ready0", ready0, 0);
    chk("rst_tx1", tx1, 1);
    chk("rst_ready1", ready1, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", ready0, 1);
    tick();

    // Single sample, default rates
    push(0, 16'h1234, n);
    chk("tx_idle_at_N", tx0, 1);
    chk("busy_at_N", busy0, 1);
    tick();
    chk("tx_idle_at_N1", tx0, 1);
    tick();
    chk("tx_start_at_N2", tx0, 0);
    wait_bytes(0, 3, 40000);
    check_frame(0, 16'h1234, s);
    chk("first_start_cycle", s - n, 2);
    wait_idle(0);
    chk("busy_fall_default", cyc - s, 30 * BC0);
    chk("tx_idle_after", tx0, 1);

    // Small rate configuration
    push(1, 16'hFF00, n);
    wait_bytes(1, 3, 2000);
    check_frame(1, 16'hFF00, s);
    chk("small_first_start", s - n, 2);
    wait_idle(1);
    chk("small_frame_len", cyc - s, 300);

    // Continuous valid with incrementing samples
    k = 1; acc = 0; g = 0;
    sample1 = 16'(k); valid1 = 1'b1;
    while (ready1 === 1'b1 && g < 100) begin
      tick(); g++;
      acc++; expq.push_back(16'(k));
      k++; sample1 = 16'(k);
    end
    valid1 = 1'b0;
    chk("accepted_before_full", acc, 8 + 1);
    for (int j = 0; j < 3; j++) begin
      push(1, 16'(k), n);
      expq.push_back(16'(k));
      k++;
    end
    prev = 0;
    for (int f = 0; f < 12; f++) begin
      wait_bytes(1, 3, 2000);
      v = expq.pop_front();
      check_frame(1, v, s);
      if (f > 0) chk("frame_gap", s - (prev + 30 * BC1), 2);
      prev = s;
    end
    wait_idle(1);
    chk("no_extra_bytes", q1.size(), 0);

    // Push coinciding with a LOAD pop at count 3
    expq.delete();
    for (int j = 0; j < 4; j++) begin
      v = 16'($urandom);
      expq.push_back(v);
      push(1, v, n);
      if (j == 0) s = n + 2;
    end
    tgt = s + 30 * BC1 + 1;
    g = 0;
    while (cyc < tgt && g < 2000) begin tick(); g++; end
    chk("reach_load_cycle", cyc, tgt);
    chk("count_before_pop", dut1.u_fifo.o_count, 3);
    v = 16'($urandom);
    expq.push_back(v);
    sample1 = v; valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    chk("count_after_push_pop", dut1.u_fifo.o_count, 3);
    chk("next_frame_started", tx1, 0);
    for (int f = 0; f < 5; f++) begin
      wait_bytes(1, 3, 2000);
      v = expq.pop_front();
      check_frame(1, v, s);
    end
    wait_idle(1);

    // Reset pulse during the HI byte
    for (int j = 0; j < 3; j++) begin
      push(1, 16'($urandom), n);
      if (j == 0) s = n + 2;
    end
    tgt = s + 10 * BC1 + 15;
    g = 0;
    while (cyc < tgt && g < 2000) begin tick(); g++; end
    rst = 1'b1;
    tick();
    chk("rst_mid_tx", tx1, 1);
    chk("rst_mid_busy", busy1, 0);
    chk("rst_mid_ready", ready1, 0);
    #2 rst = 1'b0;
    repeat (400) tick();
    chk("only_sync_before_rst", q1.size(), 1);
    if (q1.size() > 0) begin
      chk("sync_before_rst", q1[0].b, 8'hA5);
      q1.delete();
    end
    chk("idle_after_rst_busy", busy1, 0);
    chk("idle_after_rst_tx", tx1, 1);
    push(1, 16'h8001, n);
    wait_bytes(1, 3, 2000);
    check_frame(1, 16'h8001, s);
    wait_idle(1);
    chk("nothing_after_8001", q1.size(), 0);

    // Negative sample passes through bit-exact
    push(0, 16'h8000, n);
    wait_bytes(0, 3, 40000);
    check_frame(0, 16'h8000, s);
    wait_idle(0);
    chk("nothing_after_8000", q0.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule

// File: doc/uart_sample_tx.md
# uart_sample_tx

Framed UART transmitter for audio samples: accepts 16-bit samples on a valid/ready handshake, buffers them in a small FIFO, and sends each one as a 3-byte frame on the serial line. Each frame is a 0xA5 sync byte, then the high byte, then the low byte, all 8N1, LSB first. It is the outbound counterpart of the UART command receive path. It lets captured or processed audio stream to a host over the same `tx_pin` used for echo/debug.

## Interface
- `CLK_RATE`, 12000000, system clock frequency in Hz
- `BAUD_RATE`, 115200, line rate in bits/s
- `FIFO_DEPTH`, 8, sample FIFO entries; power of two, ≥ 2
- `clk`  in  1  system clock; the block is on one clock only
- `rst`  in  1  reset, synchronous and active-high
- `sample`  in  16  sample to send, two's complement, passed through bit-exact
- `sample_valid`  in  1  `sample` is valid this cycle
- `sample_ready`  out  1  the FIFO can accept a sample this cycle
- `tx_bits`  out  1  UART serial output; idle high
- `busy`  out  1  a frame is in flight or the FIFO is non-empty

## Operation
- Bit period: BIT_CYCLES = CLK_RATE / BAUD_RATE, truncated integer division; 104 at the defaults. One bit counter is wide enough for BIT_CYCLES−1.
- Push: a sample is written into the FIFO on any rising edge where `sample_valid && sample_ready`.
- `sample_ready` = !full && !rst. It is combinational from the FIFO count.
- `busy` = (frame FSM != IDLE) || !empty. It is registered.
- Frame FSM states:
  - IDLE → LOAD when the FIFO is non-empty.
  - LOAD pops the head into a 16-bit frame register (one cycle), then → HDR.
  - HDR sends 0xA5, then → HI.
  - HI sends frame[15:8], then → LO.
  - LO sends frame[7:0], then → IDLE.
- Byte sub-FSM states: START, DATA, STOP.
  - START: `tx_bits`=0 for BIT_CYCLES cycles.
  - DATA: eight bits, LSB first, BIT_CYCLES cycles each.
  - STOP: `tx_bits`=1 for BIT_CYCLES cycles.
- Bytes within a frame are contiguous: the next START follows STOP with no gap.
- A frame occupies 30·BIT_CYCLES cycles.
- Simultaneous push and pop in the same cycle: count is unchanged and both operate correctly.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty come from a count of width clog2(FIFO_DEPTH)+1.
- Reset values: `tx_bits`=1, `busy`=0, FIFO empty, both FSMs IDLE, `sample_ready`=0 while `rst` is high.
- Reset mid-frame:
  - `tx_bits` is 1 on the cycle after the `rst` edge.
  - The partial frame is abandoned (no completion) and the FIFO contents are discarded.
  - The host resynchronises on the next 0xA5.

## Timing
- Accept at edge N with the block idle:
  - LOAD at N+1.
  - Start bit of 0xA5 on `tx_bits` from N+2.
- Back-to-back frames: exactly 2 idle-high cycles between the last STOP of one frame and the next START (IDLE + LOAD).
- With `sample_valid` held high from idle, FIFO_DEPTH+1 samples are accepted before `sample_ready` falls. One sample sits in the frame register.
- `sample_ready` rises in the cycle after the LOAD pop that makes the FIFO non-full.
- `busy` falls on the cycle after the last STOP bit ends, if the FIFO is empty.

## Structure
- Shared package constants:
  - SYNC_BYTE = 8'hA5
  - FRAME_BYTES = 3
  - frame FSM state enum
  - byte FSM state enum
- One sub-module: `sample_fifo`. It is a synchronous FIFO parameterised by width and depth, with push/pop/full/empty/count. It resets empty under `rst`.
- The baud counter, byte serialiser and frame FSM stay in `uart_sample_tx`.

## Test plan
- Single sample 0x1234, default parameters:
  - `tx_bits` low at N+2.
  - Decoded bytes are A5, 12, 34.
  - Each bit lasts 104 cycles.
  - `busy` falls 3120 cycles after the first start bit.
- CLK_RATE=1000, BAUD_RATE=100, sample 0xFF00: bytes A5, FF, 00 with 10-cycle bits; frame is 300 cycles.
- Continuous `sample_valid` with incrementing samples 0x0001…:
  - Exactly 9 accepted before `sample_ready` falls.
  - Frames leave in order with 2-cycle gaps.
  - No sample is lost or duplicated.
- Push on the exact cycle of a LOAD pop with the FIFO at count 3: count stays 3, and later frames keep their order.
- Assert `rst` for 1 cycle during the HI byte:
  - `tx_bits` is 1 the next cycle.
  - `busy`=0.
  - The queued samples are never transmitted.
  - A new sample 0x8001 then sends A5, 80, 01 correctly.
- Negative sample 0x8000: bytes A5, 80, 00 on the line, with no sign manipulation.
